// File: rtl/hnf_txreq_lcrd_pkg.sv
// Shared CHI request-channel definitions for the HN-F TXREQ link sender.
// Includes the request flit layout, opcodes, the credit limit and the link state encoding.
package hnf_txreq_lcrd_pkg;

    localparam logic [5:0]  REQ_OPC_LCRDRETURN = 6'h00;
    localparam logic [5:0]  REQ_OPC_READNOSNP  = 6'h04;
    localparam int unsigned CHI_LCRD_MAX       = 15;
    localparam logic [10:0] CHI_SN_NODE_ID     = 11'h020;

    typedef struct packed {
        logic [3:0]  qos;
        logic [10:0] tgt_id;
        logic [10:0] src_id;
        logic [11:0] txn_id;
        logic [5:0]  opcode;
        logic [2:0]  size;
        logic [47:0] addr;
        logic        ns;
        logic        allow_retry;
        logic [3:0]  order;
        logic [3:0]  mem_attr;
        logic        exp_comp_ack;
    } reqflit_t;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DEACT = 2'd2
    } txlink_state_e;

    // Credit-return flits carry only the opcode and the SN target; every other field is zero.
    function automatic reqflit_t lcrd_return_flit();
        reqflit_t f;
        f        = '0;
        f.opcode = REQ_OPC_LCRDRETURN;
        f.tgt_id = CHI_SN_NODE_ID;
        return f;
    endfunction

endpackage

// File: rtl/hnf_req_fifo.sv
// Synchronous FIFO of request flits with registered occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module hnf_req_fifo
    import hnf_txreq_lcrd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  reqflit_t                     push_flit,
    input  logic                         pop,
    output reqflit_t                     head_flit,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    reqflit_t          mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     cnt_q;
    logic              do_push;
    logic              do_pop;

    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;
    assign head_flit = mem_q[rd_ptr_q];

    // A push while full is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_flit;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/hnf_txreq_lcrd.sv
// HN-F to SN-F TXREQ link sender: buffers request flits, spends L-credits to send them,
// and returns every held credit while the link is being deactivated.
module hnf_txreq_lcrd
    import hnf_txreq_lcrd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LCRD_MAX   = CHI_LCRD_MAX
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     enq_valid,
    input  reqflit_t enq_flit,
    output logic     enq_ready,
    input  logic     link_active,
    output reqflit_t TXREQFLIT,
    output logic     TXREQFLITV,
    output logic     TXREQFLITPEND,
    input  logic     TXREQLCRDV,
    output logic     link_stopped,
    output logic     crd_err
);

    localparam int unsigned CW  = $clog2(LCRD_MAX + 1);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CRD_MAX = CW'(LCRD_MAX);

    txlink_state_e  state_q;
    logic [CW-1:0]  crd_cnt_q;
    logic [CW-1:0]  crd_cnt_d;
    logic           crd_err_q;
    logic           crd_err_d;
    reqflit_t       flit_q;
    logic           flitv_q;

    reqflit_t       head_flit;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FCW-1:0] fifo_count;

    logic           crd_avail;
    logic           send_req;
    logic           send_ret;
    logic           send;

    hnf_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (enq_valid && !fifo_full),
        .push_flit (enq_flit),
        .pop       (send_req),
        .head_flit (head_flit),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Sends are decided from the registered count only, so a credit is usable the cycle after
    // it arrives. Credit return in DEACT never pops the FIFO.
    assign crd_avail = (crd_cnt_q != '0);
    assign send_req  = (state_q == RUN) && !fifo_empty && crd_avail;
    assign send_ret  = (state_q == DEACT) && crd_avail;
    assign send      = send_req || send_ret;

    always_comb begin
        crd_cnt_d = crd_cnt_q;
        crd_err_d = crd_err_q;
        if (TXREQLCRDV && !send) begin
            if (crd_cnt_q == CRD_MAX) begin
                crd_err_d = 1'b1;
            end else begin
                crd_cnt_d = crd_cnt_q + 1'b1;
            end
        end else if (!TXREQLCRDV && send) begin
            crd_cnt_d = crd_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= STOP;
            crd_cnt_q <= '0;
            crd_err_q <= 1'b0;
            flit_q    <= '0;
            flitv_q   <= 1'b0;
        end else begin
            crd_cnt_q <= crd_cnt_d;
            crd_err_q <= crd_err_d;
            flitv_q   <= send;
            if (send_ret) begin
                flit_q <= lcrd_return_flit();
            end else if (send_req) begin
                flit_q <= head_flit;
            end
            unique case (state_q)
                STOP: begin
                    if (link_active) state_q <= RUN;
                end
                RUN: begin
                    if (!link_active) state_q <= DEACT;
                end
                DEACT: begin
                    // Wait for the last return flit to leave the output register.
                    if (link_active) begin
                        state_q <= RUN;
                    end else if (!crd_avail && !flitv_q) begin
                        state_q <= STOP;
                    end
                end
                default: state_q <= STOP;
            endcase
        end
    end

    assign enq_ready     = !fifo_full;
    assign TXREQFLIT     = flit_q;
    assign TXREQFLITV    = flitv_q;
    assign TXREQFLITPEND = ((state_q == RUN) && (fifo_count != '0)) ||
                           ((state_q == DEACT) && crd_avail);
    assign link_stopped  = (state_q == STOP);
    assign crd_err       = crd_err_q;

endmodule

// File: tb/tb_hnf_txreq_lcrd.sv
// Directed bench for hnf_txreq_lcrd: credit gating, ordering, full FIFO, overflow,
// deactivation credit return and reset during a burst.
module tb_hnf_txreq_lcrd;
    import hnf_txreq_lcrd_pkg::*;

    logic     clock = 1'b0;
    logic     reset;
    logic     enq_valid;
    reqflit_t enq_flit;
    logic     enq_ready;
    logic     link_active;
    reqflit_t TXREQFLIT;
    logic     TXREQFLITV;
    logic     TXREQFLITPEND;
    logic     TXREQLCRDV;
    logic     link_stopped;
    logic     crd_err;

    always #5 clock = ~clock;

    hnf_txreq_lcrd #(
        .FIFO_DEPTH (4),
        .LCRD_MAX   (15)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enq_valid     (enq_valid),
        .enq_flit      (enq_flit),
        .enq_ready     (enq_ready),
        .link_active   (link_active),
        .TXREQFLIT     (TXREQFLIT),
        .TXREQFLITV    (TXREQFLITV),
        .TXREQFLITPEND (TXREQFLITPEND),
        .TXREQLCRDV    (TXREQLCRDV),
        .link_stopped  (link_stopped),
        .crd_err       (crd_err)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    reqflit_t    sent_q[$];
    int unsigned sent_cyc_q[$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after each rising edge; sent flits are logged there.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (TXREQFLITV) begin
            sent_q.push_back(TXREQFLIT);
            sent_cyc_q.push_back(cyc);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        enq_valid   = 1'b0;
        enq_flit    = '0;
        link_active = 1'b0;
        TXREQLCRDV  = 1'b0;
        steps(2);
        reset = 1'b0;
        sent_q.delete();
        sent_cyc_q.delete();
    endtask

    task automatic enq(input reqflit_t f);
        enq_valid = 1'b1;
        enq_flit  = f;
        step();
        enq_valid = 1'b0;
    endtask

    task automatic grant(input int n);
        for (int i = 0; i < n; i++) begin
            TXREQLCRDV = 1'b1;
            step();
            TXREQLCRDV = 1'b0;
        end
    endtask

    function automatic reqflit_t rd_flit(input logic [11:0] txn, input logic [47:0] addr);
        reqflit_t f;
        f        = '0;
        f.opcode = REQ_OPC_READNOSNP;
        f.tgt_id = CHI_SN_NODE_ID;
        f.src_id = 11'h001;
        f.txn_id = txn;
        f.addr   = addr;
        f.size   = 3'd6;
        return f;
    endfunction

    function automatic logic [11:0] sent_txn(input int idx);
        if (idx < sent_q.size()) return sent_q[idx].txn_id;
        return 12'hfff;
    endfunction

    function automatic reqflit_t sent_flit(input int idx);
        if (idx < sent_q.size()) return sent_q[idx];
        return '1;
    endfunction

    function automatic int sent_gap(input int idx);
        if (idx < sent_cyc_q.size() && idx > 0) return int'(sent_cyc_q[idx] - sent_cyc_q[idx-1]);
        return -1;
    endfunction

    function automatic int count_op(input logic [5:0] op);
        int n = 0;
        foreach (sent_q[i]) if (sent_q[i].opcode == op) n++;
        return n;
    endfunction

    reqflit_t exp_ret;

    initial begin
        exp_ret        = '0;
        exp_ret.opcode = 6'h00;
        exp_ret.tgt_id = CHI_SN_NODE_ID;

        // Reset values
        do_reset();
        check_eq("rst_enq_ready", enq_ready, 1);
        check_eq("rst_link_stopped", link_stopped, 1);
        check_eq("rst_flitv", TXREQFLITV, 0);
        check_eq("rst_pend", TXREQFLITPEND, 0);
        check_eq("rst_crd_err", crd_err, 0);
        check_eq("rst_flit", TXREQFLIT, 0);

        // Credit gating
        link_active = 1'b1;
        step();
        check_eq("t1_run", link_stopped, 0);
        enq(rd_flit(12'h005, 48'h1000));
        check_eq("t1_pend", TXREQFLITPEND, 1);
        steps(3);
        check_eq("t1_gated", sent_q.size(), 0);
        check_eq("t1_pend_held", TXREQFLITPEND, 1);
        grant(1);
        check_eq("t1_no_send_on_arrival", TXREQFLITV, 0);
        step();
        check_eq("t1_flitv", TXREQFLITV, 1);
        check_eq("t1_txn", TXREQFLIT.txn_id, 12'h005);
        check_eq("t1_addr", TXREQFLIT.addr, 48'h1000);
        check_eq("t1_opcode", TXREQFLIT.opcode, 6'h04);
        step();
        check_eq("t1_pulse", TXREQFLITV, 0);
        check_eq("t1_flit_hold", TXREQFLIT.txn_id, 12'h005);
        check_eq("t1_pend_empty", TXREQFLITPEND, 0);
        enq(rd_flit(12'h006, 48'h1040));
        steps(4);
        check_eq("t1_crd_zero", sent_q.size(), 1);

        // Burst and order
        do_reset();
        link_active = 1'b1;
        step();
        grant(3);
        for (int i = 1; i <= 4; i++) enq(rd_flit(12'(i), 48'h2000 + 48'(64 * i)));
        steps(3);
        check_eq("t2_sent3", sent_q.size(), 3);
        for (int i = 0; i < 3; i++) check_eq("t2_order", sent_txn(i), 12'(i + 1));
        check_eq("t2_b2b_1", sent_gap(1), 1);
        check_eq("t2_b2b_2", sent_gap(2), 1);
        grant(1);
        step();
        check_eq("t2_sent4", sent_q.size(), 4);
        check_eq("t2_txn4", sent_txn(3), 12'h004);

        // Full FIFO
        do_reset();
        link_active = 1'b1;
        step();
        for (int i = 0; i < 4; i++) enq(rd_flit(12'(16 + i), 48'h3000));
        check_eq("t3_full", enq_ready, 0);
        enq_valid = 1'b1;
        enq_flit  = rd_flit(12'h014, 48'h3000);
        steps(2);
        enq_valid = 1'b0;
        check_eq("t3_still_full", enq_ready, 0);
        grant(1);
        check_eq("t3_full_before_pop", enq_ready, 0);
        step();
        check_eq("t3_ready_after_pop", enq_ready, 1);
        check_eq("t3_first_out", sent_txn(0), 12'h010);
        grant(3);
        steps(4);
        check_eq("t3_total", sent_q.size(), 4);
        for (int i = 1; i < 4; i++) check_eq("t3_order", sent_txn(i), 12'(16 + i));
        check_eq("t3_fifth_dropped", TXREQFLITPEND, 0);

        // Credit arrives in the send-decision cycle
        do_reset();
        link_active = 1'b1;
        step();
        grant(1);
        enq_valid = 1'b1;
        enq_flit  = rd_flit(12'h020, 48'h4000);
        step();
        enq_valid  = 1'b0;
        TXREQLCRDV = 1'b1;
        step();
        TXREQLCRDV = 1'b0;
        check_eq("t4_sim_flitv", TXREQFLITV, 1);
        check_eq("t4_sim_txn", TXREQFLIT.txn_id, 12'h020);
        enq(rd_flit(12'h021, 48'h4040));
        step();
        check_eq("t4_kept_crd", TXREQFLIT.txn_id, 12'h021);
        enq(rd_flit(12'h022, 48'h4080));
        steps(3);
        check_eq("t4_crd_zero", sent_q.size(), 2);

        // Overflow: 16 grants in STOP
        do_reset();
        grant(15);
        check_eq("t4_no_err_at_max", crd_err, 0);
        grant(1);
        check_eq("t4_crd_err", crd_err, 1);
        check_eq("t4_stop_kept", link_stopped, 1);
        link_active = 1'b1;
        step();
        link_active = 1'b0;
        step();
        check_eq("t4_deact_pend", TXREQFLITPEND, 1);
        steps(25);
        check_eq("t4_ret15", count_op(REQ_OPC_LCRDRETURN), 15);
        check_eq("t4_sent15", sent_q.size(), 15);
        check_eq("t4_err_sticky", crd_err, 1);
        check_eq("t4_stopped", link_stopped, 1);

        // Deactivation with 5 credits and 2 flits queued
        do_reset();
        grant(5);
        link_active = 1'b1;
        step();
        link_active = 1'b0;
        enq_valid   = 1'b1;
        enq_flit    = rd_flit(12'h030, 48'h5000);
        step();
        enq_flit = rd_flit(12'h031, 48'h5040);
        step();
        enq_valid = 1'b0;
        steps(12);
        check_eq("t5_ret5", count_op(REQ_OPC_LCRDRETURN), 5);
        check_eq("t5_no_pop", count_op(REQ_OPC_READNOSNP), 0);
        check_eq("t5_ret_flit", sent_flit(0), exp_ret);
        check_eq("t5_stopped", link_stopped, 1);
        check_eq("t5_enq_ready", enq_ready, 1);
        sent_q.delete();
        sent_cyc_q.delete();
        link_active = 1'b1;
        step();
        check_eq("t5_fifo_kept", TXREQFLITPEND, 1);
        grant(2);
        steps(2);
        check_eq("t5_drain", sent_q.size(), 2);
        check_eq("t5_drain0", sent_txn(0), 12'h030);
        check_eq("t5_drain1", sent_txn(1), 12'h031);

        // Reset mid-burst
        do_reset();
        link_active = 1'b1;
        step();
        grant(4);
        for (int i = 0; i < 3; i++) enq(rd_flit(12'(64 + i), 48'h6000));
        check_eq("t6_burst_active", TXREQFLITV, 1);
        reset = 1'b1;
        step();
        check_eq("t6_flitv", TXREQFLITV, 0);
        check_eq("t6_enq_ready", enq_ready, 1);
        check_eq("t6_stopped", link_stopped, 1);
        check_eq("t6_pend", TXREQFLITPEND, 0);
        check_eq("t6_flit", TXREQFLIT, 0);
        reset = 1'b0;
        step();
        enq(rd_flit(12'h050, 48'h7000));
        sent_q.delete();
        steps(4);
        check_eq("t6_crd_cleared", sent_q.size(), 0);
        check_eq("t6_pend_after", TXREQFLITPEND, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hnf_txreq_lcrd.md
Name: hnf_txreq_lcrd

Overview:
- Upstream link-layer sender for the HN-F to SN-F TXREQ channel.
- Accepts request flits (ReadNoSnp / DMT requests) from the HN-F request pipeline and buffers them in a FIFO.
- Tracks L-credits granted by the SN-F and drives TXREQFLIT / TXREQFLITV / TXREQFLITPEND only when a credit is held.
- On link deactivation, returns all held credits using ReqLCrdReturn flits.

Parameters:
- FIFO_DEPTH, 4: request buffer entries; power of 2, minimum 2.
- LCRD_MAX, 15: maximum L-credits held. This is the CHI link limit.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- enq_valid  in  1  pipeline offers a request flit.
- enq_flit  in  reqflit_t  request flit, passed through unmodified.
- enq_ready  out  1  FIFO not full; the flit is accepted when enq_valid and enq_ready are both high.
- link_active  in  1  1 = link up (RUN); 0 = deactivate and return credits.
- TXREQFLIT  out  reqflit_t  registered outgoing flit.
- TXREQFLITV  out  1  registered flit valid, one-cycle pulse per flit.
- TXREQFLITPEND  out  1  flit-pending hint to the receiver.
- TXREQLCRDV  in  1  one L-credit granted this cycle.
- link_stopped  out  1  state is STOP.
- crd_err  out  1  sticky flag: credit overflow observed.

Behaviour:
- Reset values:
  - All outputs 0 except enq_ready = 1 and link_stopped = 1.
  - FIFO empty, credit count 0, state STOP, TXREQFLIT = '0.
- States: STOP, RUN, DEACT.
  - STOP -> RUN when link_active = 1.
  - RUN -> DEACT when link_active = 0. Flits already in the FIFO are held, not dropped.
  - DEACT -> STOP when credit count = 0 and no return flit is in flight.
  - DEACT -> RUN if link_active returns to 1 before reaching STOP.
- Credit counter (width clog2(LCRD_MAX+1)):
  - +1 on TXREQLCRDV; -1 on any flit send.
  - Credit arrival and send in the same cycle leave the count unchanged.
  - TXREQLCRDV at count = LCRD_MAX: count saturates and crd_err sets. crd_err clears only on reset.
  - TXREQLCRDV in STOP is still counted. The credit is returned on the next DEACT.
- Send decision in cycle N: in RUN, if the FIFO is non-empty and count > 0:
  - pop the FIFO head;
  - load TXREQFLIT;
  - TXREQFLITV = 1 in cycle N+1.
- Credits are only spent from the registered count. A credit arriving in cycle N is usable from N+1.
- In DEACT with count > 0, send a return flit:
  - Opcode = ReqLCrdReturn (6'h00), TxnID = 0, other fields 0, TgtID = enq-side default SN TgtID constant.
  - Credit return has priority over the FIFO; no FIFO pops occur in DEACT.
- Throughput: at most one flit per cycle. Back-to-back sends are allowed when credits are available.
- TXREQFLITPEND is combinational from the state flops:
  - = (state == RUN and FIFO non-empty) or (state == DEACT and count > 0).
  - It is therefore high in the cycle before every TXREQFLITV.
- TXREQFLITV in cycles without a send is 0. TXREQFLIT holds its last value.
- FIFO:
  - enq_ready = !full, registered count based.
  - Enqueue and dequeue in the same cycle are allowed when full; the count is unchanged and enq_ready stays 0.
  - Pointers wrap modulo FIFO_DEPTH.
  - Flits leave in strict FIFO order.
- Reset mid-operation: FIFO contents, credits and state are discarded; outputs go to reset values the next cycle.

Decomposition:
- Shared chi package (existing reqflit_t):
  - add REQ_OPC_LCRDRETURN = 6'h00 and REQ_OPC_READNOSNP = 6'h04;
  - add CHI_LCRD_MAX = 15 and a default SN node ID constant;
  - add a txlink_state_e enum {STOP, RUN, DEACT}.
- One sub-module, hnf_req_fifo: parameterised synchronous FIFO of reqflit_t with full/empty/count outputs.
- Credit counter, state machine and output register live in the top level.

Test Plan:
- Credit gating: reset, link_active = 1, enqueue 1 ReadNoSnp (Addr 0x1000, TxnID 0x05), no credit -> TXREQFLITV stays 0 and PEND = 1. Pulse TXREQLCRDV once -> flit appears with TxnID 0x05 two cycles later; credit count returns to 0.
- Burst and order: grant 3 credits, enqueue TxnIDs 1, 2, 3, 4 -> TxnIDs 1, 2, 3 sent on consecutive cycles. 4 is held until a 4th credit arrives, then sent.
- Full FIFO: with 0 credits, enqueue 4 flits -> enq_ready = 0 and a 5th enq_valid is not accepted. Add 1 credit -> enq_ready returns to 1 the cycle after the pop.
- Simultaneous events: count = 1, TXREQLCRDV asserted in the send-decision cycle -> flit sent and count stays 1. 16 grants with no sends -> count = 15 and crd_err = 1.
- Deactivation: hold 5 credits, FIFO holding 2 flits, drop link_active -> exactly 5 ReqLCrdReturn flits (Opcode 0x00), no FIFO pops, then link_stopped = 1 with the FIFO still holding 2.
- Reset mid-burst: reset asserted during back-to-back sends -> the next cycle TXREQFLITV = 0, enq_ready = 1, link_stopped = 1 and credits = 0.
